mux_nx1_scan: RTL and testbench

Parametrised N-input, W-bit registered multiplexer with two modes. In manual mode a validated select picks the channel, and the output is resampled every cycle. In auto-scan mode an internal sequencer steps through channels 0..limit with a programmable dwell per channel. It generalises the fixed 16:1 single-bit select trees into one clocked block. It feeds probe and observation logic that needs a tagged, strobed sample stream rather than a raw combinational path.

---
 rtl/mux_nx1_scan.sv | 137 +++++++++++++
 tb/tb_mux_nx1_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_scan.sv
// Registered N:1 channel multiplexer with manual select and auto-scan sequencer.
// Latency: one clock from select/data at an edge to out_o; scan samples every DWELL edges.
// No backpressure: out_vld_o is a strobe and the consumer must take every sample.
module mux_nx1_scan #(
    parameter int N_INPUTS = 16,
    parameter int DATA_W   = 1,
    parameter int DWELL    = 4,
    localparam int SEL_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_INPUTS*DATA_W-1:0] inp_i,
    input  logic                       en_i,
    input  logic                       mode_i,
    input  logic [SEL_W-1:0]           sel_i,
    input  logic                       sel_vld_i,
    input  logic [SEL_W-1:0]           scan_last_i,
    output logic [DATA_W-1:0]          out_o,
    output logic [SEL_W-1:0]           out_idx_o,
    output logic                       out_vld_o,
    output logic                       sel_err_o
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N_INPUTS);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t            state;
    state_t            next_state;
    logic [SEL_W-1:0]  cur_sel;
    logic [SEL_W-1:0]  cur_sel_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] out_nxt;
    logic [SEL_W-1:0]  out_idx_nxt;
    logic              vld_nxt;
    logic              err_nxt;
    logic [SEL_W-1:0]  pick;
    logic [SEL_W-1:0]  limit;
    logic              sel_in_range;

    logic [DATA_W-1:0] chan [N_INPUTS];

    genvar k;
    generate
        for (k = 0; k < N_INPUTS; k++) begin : g_chan
            assign chan[k] = inp_i[k*DATA_W +: DATA_W];
        end
    endgenerate

    assign sel_in_range = ({1'b0, sel_i} < N_EXT);
    // Clamp the scan end so the sequencer never addresses a missing channel.
    assign limit = (scan_last_i > LAST_CH) ? LAST_CH : scan_last_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = IDLE;
        cur_sel_nxt = cur_sel;
        cnt_nxt     = cnt;
        out_nxt     = out_o;
        out_idx_nxt = out_idx_o;
        vld_nxt     = 1'b0;
        err_nxt     = sel_err_o;
        pick        = cur_sel;

        if (en_i) begin
            next_state = mode_i ? SCAN : MANUAL;
        end

        case (next_state)
            IDLE: begin
                cnt_nxt = '0;
            end
            MANUAL: begin
                vld_nxt = 1'b1;
                if (sel_vld_i) begin
                    if (sel_in_range) begin
                        pick        = sel_i;
                        cur_sel_nxt = sel_i;
                        err_nxt     = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                out_nxt     = chan[pick];
                out_idx_nxt = pick;
            end
            SCAN: begin
                // Entering scan (including a same-edge select) restarts at channel 0 with no sample.
                if (state != SCAN) begin
                    cur_sel_nxt = '0;
                    cnt_nxt     = '0;
                end else if (cnt == CNT_LAST) begin
                    out_nxt     = chan[cur_sel];
                    out_idx_nxt = cur_sel;
                    vld_nxt     = 1'b1;
                    cnt_nxt     = '0;
                    cur_sel_nxt = (cur_sel >= limit) ? '0 : cur_sel + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_sel   <= '0;
            cnt       <= '0;
            out_o     <= '0;
            out_idx_o <= '0;
            out_vld_o <= 1'b0;
            sel_err_o <= 1'b0;
        end else begin
            cur_sel   <= cur_sel_nxt;
            cnt       <= cnt_nxt;
            out_o     <= out_nxt;
            out_idx_o <= out_idx_nxt;
            out_vld_o <= vld_nxt;
            sel_err_o <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan (12 channels x 8 bits, dwell 4); sample stream
// checked by a scoreboard queue, timing and flags checked inline.
module tb_mux_nx1_scan;

    localparam int N     = 12;
    localparam int W     = 8;
    localparam int DWELL = 4;
    localparam int SW    = 4;

    typedef struct packed {
        logic [SW-1:0] idx;
        logic [W-1:0]  dat;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [N*W-1:0] inp;
    logic          en;
    logic          mode;
    logic [SW-1:0] sel;
    logic          sel_vld;
    logic [SW-1:0] scan_last;
    logic [W-1:0]  out;
    logic [SW-1:0] out_idx;
    logic          out_vld;
    logic          sel_err;

    logic [W-1:0]  ch [N];
    exp_t          exp_q [$];
    int            vectors;
    int            miscompares;
    int            dw;

    mux_nx1_scan #(.N_INPUTS(N), .DATA_W(W), .DWELL(DWELL)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .inp_i      (inp),
        .en_i       (en),
        .mode_i     (mode),
        .sel_i      (sel),
        .sel_vld_i  (sel_vld),
        .scan_last_i(scan_last),
        .out_o      (out),
        .out_idx_o  (out_idx),
        .out_vld_o  (out_vld),
        .sel_err_o  (sel_err)
    );

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_inp
            assign inp[g*W +: W] = ch[g];
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [W-1:0] d);
        exp_t t;
        t.idx = SW'(k);
        t.dat = d;
        exp_q.push_back(t);
    endtask

    task automatic push_ch(input int k);
        push(k, 8'hA0 + 8'(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps through scan edges checking the strobe lands once every DWELL edges.
    task automatic scan_edges(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            dw++;
            chk("scan_vld", 32'(out_vld), 32'((dw % DWELL) == 0));
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_vld) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_sample: got idx %0d data %02h, expected no sample", out_idx, out);
            end else begin
                e = exp_q.pop_front();
                chk("sample_idx", 32'(out_idx), 32'(e.idx));
                chk("sample_dat", 32'(out), 32'(e.dat));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        dw          = 0;
        rst         = 1'b0;
        en          = 1'b0;
        mode        = 1'b0;
        sel         = '0;
        sel_vld     = 1'b0;
        scan_last   = '0;
        for (int k = 0; k < N; k++) ch[k] = 8'hA0 + 8'(k);

        #1 rst = 1'b1;
        #2;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_idx", 32'(out_idx), 32'h0);
        chk("rst_vld", 32'(out_vld), 32'h0);
        chk("rst_err", 32'(sel_err), 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Manual select, hold, and data tracking on the held channel
        en = 1'b1; mode = 1'b0; sel = 4'd5; sel_vld = 1'b1;
        push(5, 8'hA5);
        rst = 1'b0;
        step();
        chk("man_err", 32'(sel_err), 32'h0);
        sel_vld = 1'b0; push(5, 8'hA5); step();
        ch[5] = 8'h3C; push(5, 8'h3C); step();
        ch[5] = 8'hA5;

        // Out-of-range selects: sticky error, current channel keeps sampling
        sel = 4'd13; sel_vld = 1'b1; push(5, 8'hA5); step();
        chk("err_set", 32'(sel_err), 32'h1);
        sel_vld = 1'b0; push(5, 8'hA5); step();
        chk("err_sticky", 32'(sel_err), 32'h1);
        sel = 4'd2; sel_vld = 1'b1; push(2, 8'hA2); step();
        chk("err_clear", 32'(sel_err), 32'h0);
        sel = 4'd11; push(11, 8'hAB); step();
        chk("err_last_ch", 32'(sel_err), 32'h0);
        sel = 4'd12; push(11, 8'hAB); step();
        chk("err_at_n", 32'(sel_err), 32'h1);

        // Scan entry with a simultaneous select: select dropped, error held
        sel = 4'd7; scan_last = 4'd3; mode = 1'b1;
        step();
        dw = 0;
        chk("entry_vld", 32'(out_vld), 32'h0);
        chk("entry_err", 32'(sel_err), 32'h1);
        chk("entry_hold_idx", 32'(out_idx), 32'd11);
        push_ch(0); push_ch(1); push_ch(2); push_ch(3); push_ch(0); push_ch(1);
        scan_edges(24);

        // Limit beyond the last channel clamps to 11
        scan_last = 4'd15;
        for (int k = 2; k < N; k++) push_ch(k);
        push_ch(0); push_ch(1);
        scan_edges(48);

        // Lower the limit below the current channel mid-scan
        scan_last = 4'd7;
        push_ch(2); push_ch(3); push_ch(4);
        scan_edges(12);
        scan_last = 4'd2;
        push_ch(5); push_ch(0); push_ch(1); push_ch(2); push_ch(0);
        scan_edges(20);

        // Idle holds the last sample, then scan restarts at channel 0
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_vld", 32'(out_vld), 32'h0);
            chk("idle_dat", 32'(out), 32'hA0);
            chk("idle_idx", 32'(out_idx), 32'h0);
        end
        en = 1'b1;
        step();
        dw = 0;
        chk("rescan_entry_vld", 32'(out_vld), 32'h0);
        push_ch(0); push_ch(1);
        scan_edges(8);

        // Asynchronous reset mid-dwell
        scan_edges(2);
        #1 rst = 1'b1;
        #1;
        chk("arst_out", 32'(out), 32'h0);
        chk("arst_idx", 32'(out_idx), 32'h0);
        chk("arst_vld", 32'(out_vld), 32'h0);
        chk("arst_err", 32'(sel_err), 32'h0);
        #1 rst = 1'b0;
        step();
        dw = 0;
        chk("post_rst_entry_vld", 32'(out_vld), 32'h0);
        push_ch(0);
        scan_edges(4);

        en = 1'b0;
        step();
        step();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
